// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stage-2 control sequencer for a 4-stage RISC pipeline.
//               - Keeps a scoreboard of in-flight register destinations.
//               - Inserts bubbles on read-after-write hazards.
//               - Flushes stages 1-3 when stage 4 takes a jump/call/return.
//               - Stalls fetch while stage 4 owns the single memory port.
//               Optional build macro: HAZ_FORWARD_EN. When it is defined,
//               the stage-4 slot is forwarded and is left out of the hazard
//               check, so each dependency stalls one cycle less.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int WB_LAT       = 3,  // issue-to-writeback latency, 1..6
    parameter int FLUSH_CYCLES = 2   // bubbles after a taken PC load, 1..4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] opcode_i,
    input  logic       op_valid_i,
    input  logic       lpc_ex_i,
    input  logic       xwr_ex_i,
    output logic       bb_o,
    output logic       hold_fetch_o,
    output logic       flush_o,
    output logic [8:0] sb_busy_o
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [8:0] C_MASK_R0 = 9'h001;
    localparam logic [8:0] C_MASK_SP = 9'h100;

    // Number of dest-pipe slots that can still cause a stall.
`ifdef HAZ_FORWARD_EN
    localparam int CHK_DEPTH = WB_LAT - 1;
`else
    localparam int CHK_DEPTH = WB_LAT;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       pipe_q [WB_LAT];
    logic [8:0]       pipe_d [WB_LAT];
    logic             bb_q, bb_d;
    logic             hold_q, hold_d;
    logic             flush_q, flush_d;

    logic [4:0] op5;
    logic [2:0] rn;
    logic [8:0] rn_mask;
    logic [8:0] src;
    logic [8:0] dst;
    logic [8:0] busy_all;
    logic [8:0] busy_chk;
    logic       hazard;
    logic       stall;
    logic       issue;

    assign op5     = opcode_i[7:3];
    assign rn      = opcode_i[2:0];
    assign rn_mask = 9'd1 << rn;

    // Decode the registers each opcode reads (src) and writes (dst).
    always_comb begin
        src = '0;
        dst = '0;
        if (op5[4]) begin
            if (op5[4:1] == 4'b1111) begin
                if (op5[0]) src = C_MASK_R0;            // OUT
                else        dst = C_MASK_R0;            // INA
            end else if (op5[0]) begin
                src = rn_mask;                          // immediate ALU
                dst = rn_mask;
            end else begin
                src = C_MASK_R0 | rn_mask;              // register-A ALU
                dst = C_MASK_R0;
            end
        end else begin
            case (op5)
                5'b00100, 5'b01000, 5'b01010: begin     // NOT, INC, DCR
                    src = rn_mask;
                    dst = rn_mask;
                end
                5'b01011: dst = rn_mask;                // MVI
                5'b01110: begin                         // LDA / RRA
                    if (rn != 3'd0) begin
                        dst = rn_mask;
                    end else begin
                        src = C_MASK_R0;
                        dst = C_MASK_R0;
                    end
                end
                5'b01111: begin                         // POP
                    src = C_MASK_SP;
                    dst = rn_mask | C_MASK_SP;
                end
                5'b01101: begin                         // PSH
                    src = rn_mask | C_MASK_SP;
                    dst = C_MASK_SP;
                end
                5'b01100: begin                         // STA / RLA
                    if (rn != 3'd0) begin
                        src = rn_mask | C_MASK_R0;
                    end else begin
                        src = C_MASK_R0;
                        dst = C_MASK_R0;
                    end
                end
                5'b00000: begin                         // calls and RTU
                    if (opcode_i[2]) begin
                        src = C_MASK_SP;
                        dst = C_MASK_SP;
                    end
                end
                5'b00110, 5'b00111, 5'b01001: begin     // cond. calls, RTC
                    src = C_MASK_SP;
                    dst = C_MASK_SP;
                end
                5'b00010: begin                         // LSP
                    if (rn == 3'd0) dst = C_MASK_SP;
                end
                default: begin
                    src = '0;
                    dst = '0;
                end
            endcase
        end
    end

    // Scoreboard: all slots form sb_busy; only the checked slots stall.
    always_comb begin
        busy_all = '0;
        busy_chk = '0;
        for (int i = 0; i < WB_LAT; i++) begin
            busy_all = busy_all | pipe_q[i];
            if (i < CHK_DEPTH) busy_chk = busy_chk | pipe_q[i];
        end
    end

    // FSM state register with flush countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: a PC load always (re)starts the flush window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (lpc_ex_i) begin
                    state_d = S_FLUSH;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            S_FLUSH: begin
                if (lpc_ex_i) begin
                    cnt_d = C_CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: a PC load overrides a hazard; memory-port use adds a hold.
    always_comb begin
        hazard  = op_valid_i & ((src & busy_chk) != 9'd0);
        stall   = (state_q == S_RUN) & ~lpc_ex_i & hazard;
        issue   = (state_q == S_RUN) & ~lpc_ex_i & op_valid_i & ~hazard;
        flush_d = (state_d == S_FLUSH);
        bb_d    = flush_d | stall;
        hold_d  = stall | xwr_ex_i;
    end

    // Dest pipe shift; a PC load kills everything younger than stage 4,
    // and the current stage-4 entry retires out of the last slot anyway.
    always_comb begin
        pipe_d[0] = issue ? dst : 9'd0;
        for (int i = 1; i < WB_LAT; i++) begin
            pipe_d[i] = lpc_ex_i ? 9'd0 : pipe_q[i-1];
        end
    end

    // Registered outputs and dest-pipe storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bb_q    <= 1'b0;
            hold_q  <= 1'b0;
            flush_q <= 1'b0;
            for (int i = 0; i < WB_LAT; i++) pipe_q[i] <= '0;
        end else begin
            bb_q    <= bb_d;
            hold_q  <= hold_d;
            flush_q <= flush_d;
            for (int i = 0; i < WB_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign bb_o         = bb_q;
    assign hold_fetch_o = hold_q;
    assign flush_o      = flush_q;
    assign sb_busy_o    = busy_all;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Table-driven self-checking bench for
//               pipeline_hazard_controller (WB_LAT=3, FLUSH_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] opcode;
    logic       op_valid;
    logic       lpc_ex;
    logic       xwr_ex;
    logic       bb;
    logic       hold_fetch;
    logic       flush;
    logic [8:0] sb_busy;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .WB_LAT       (3),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .op_valid_i   (op_valid),
        .lpc_ex_i     (lpc_ex),
        .xwr_ex_i     (xwr_ex),
        .bb_o         (bb),
        .hold_fetch_o (hold_fetch),
        .flush_o      (flush),
        .sb_busy_o    (sb_busy)
    );

    typedef struct {
        string      name;
        logic       r;
        logic [7:0] op;
        logic       v;
        logic       lpc;
        logic       xwr;
        logic       bb;
        logic       hold;
        logic       fl;
        logic [8:0] sb;
    } vec_t;

    typedef struct {
        string      name;
        logic       bb;
        logic       hold;
        logic       fl;
        logic [8:0] sb;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string n, bit r, bit [7:0] op, bit v, bit l,
                                bit x, bit b, bit h, bit f, bit [8:0] s);
        vec_t t;
        t.name = n; t.r = r; t.op = op; t.v = v; t.lpc = l; t.xwr = x;
        t.bb = b; t.hold = h; t.fl = f; t.sb = s;
        return t;
    endfunction

    task automatic add(string n, bit r, bit [7:0] op, bit v, bit l,
                       bit x, bit b, bit h, bit f, bit [8:0] s);
        vecs.push_back(mk(n, r, op, v, l, x, b, h, f, s));
    endtask

    task automatic cmp(string n, string field, logic [8:0] act, logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, field, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, sample after the edge.
    task automatic apply(input vec_t t);
        exp_t e;
        rst      = t.r;
        opcode   = t.op;
        op_valid = t.v;
        lpc_ex   = t.lpc;
        xwr_ex   = t.xwr;
        e.name = t.name; e.bb = t.bb; e.hold = t.hold; e.fl = t.fl; e.sb = t.sb;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: got empty expected entry", t.name);
        end else begin
            e = sbq.pop_front();
            cmp(e.name, "bb",    {8'd0, bb},         {8'd0, e.bb});
            cmp(e.name, "hold",  {8'd0, hold_fetch}, {8'd0, e.hold});
            cmp(e.name, "flush", {8'd0, flush},      {8'd0, e.fl});
            cmp(e.name, "sb",    sb_busy,            e.sb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = 8'h00; op_valid = 1'b0; lpc_ex = 1'b0; xwr_ex = 1'b0;

        //   name           rst op     v  lpc xwr  bb hold fl sb
        add("rst0",          1, 8'h41, 1, 0, 0,   0, 0, 0, 9'h000);
        add("rst1",          1, 8'h41, 1, 0, 0,   0, 0, 0, 9'h000);
        add("inc_r1",        0, 8'h41, 1, 0, 0,   0, 0, 0, 9'h002);
        add("not_stall1",    0, 8'h21, 1, 0, 0,   1, 1, 0, 9'h002);
        add("not_stall2",    0, 8'h21, 1, 0, 0,   1, 1, 0, 9'h002);
`ifndef HAZ_FORWARD_EN
        add("not_stall3",    0, 8'h21, 1, 0, 0,   1, 1, 0, 9'h000);
`endif
        add("not_issue",     0, 8'h21, 1, 0, 0,   0, 0, 0, 9'h002);
        add("drain_a",       0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("drain_b",       0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("drain_c",       0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("ada_r2",        0, 8'h82, 1, 0, 0,   0, 0, 0, 9'h001);
        add("adi_r3",        0, 8'h8B, 1, 0, 0,   0, 0, 0, 9'h009);
        add("out_stall1",    0, 8'hF8, 1, 0, 0,   1, 1, 0, 9'h009);
`ifndef HAZ_FORWARD_EN
        add("out_stall2",    0, 8'hF8, 1, 0, 0,   1, 1, 0, 9'h008);
        add("out_issue",     0, 8'hF8, 1, 0, 0,   0, 0, 0, 9'h000);
`else
        add("out_issue",     0, 8'hF8, 1, 0, 0,   0, 0, 0, 9'h008);
        add("out_drain",     0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
`endif
        add("psh_r4",        0, 8'h6C, 1, 0, 0,   0, 0, 0, 9'h100);
        add("pop_stall1",    0, 8'h7D, 1, 0, 0,   1, 1, 0, 9'h100);
        add("pop_stall2",    0, 8'h7D, 1, 0, 0,   1, 1, 0, 9'h100);
`ifndef HAZ_FORWARD_EN
        add("pop_stall3",    0, 8'h7D, 1, 0, 0,   1, 1, 0, 9'h000);
`endif
        add("pop_issue",     0, 8'h7D, 1, 0, 0,   0, 0, 0, 9'h120);
        add("pop_drain_a",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h120);
        add("pop_drain_b",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h120);
        add("pop_drain_c",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("inc_r1_f",      0, 8'h41, 1, 0, 0,   0, 0, 0, 9'h002);
        add("lpc_drop",      0, 8'h00, 0, 1, 0,   1, 0, 1, 9'h000);
        add("flush_2nd",     0, 8'h21, 1, 0, 0,   1, 0, 1, 9'h000);
        add("flush_end",     0, 8'h21, 1, 0, 0,   0, 0, 0, 9'h000);
        add("not_no_stall",  0, 8'h21, 1, 0, 0,   0, 0, 0, 9'h002);
        add("f_drain_a",     0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("f_drain_b",     0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("f_drain_c",     0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("lpc_a",         0, 8'h00, 0, 1, 0,   1, 0, 1, 9'h000);
        add("fl_a",          0, 8'h00, 0, 0, 0,   1, 0, 1, 9'h000);
        add("lpc_restart",   0, 8'h00, 0, 1, 0,   1, 0, 1, 9'h000);
        add("fl_restart",    0, 8'h00, 0, 0, 0,   1, 0, 1, 9'h000);
        add("fl_restart_end",0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("xwr_only",      0, 8'h00, 1, 0, 1,   0, 1, 0, 9'h000);
        add("xwr_release",   0, 8'h00, 1, 0, 0,   0, 0, 0, 9'h000);
        add("xwr_lpc",       0, 8'h00, 0, 1, 1,   1, 1, 1, 9'h000);
        add("xwr_lpc_fl2",   0, 8'h00, 0, 0, 0,   1, 0, 1, 9'h000);
        add("xwr_lpc_end",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("inc_r1_p",      0, 8'h41, 1, 0, 0,   0, 0, 0, 9'h002);
        add("haz_vs_lpc",    0, 8'h21, 1, 1, 0,   1, 0, 1, 9'h000);
        add("haz_lpc_fl2",   0, 8'h00, 0, 0, 0,   1, 0, 1, 9'h000);
        add("haz_lpc_end",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("call_sp",       0, 8'h05, 1, 0, 0,   0, 0, 0, 9'h100);
        add("mvi_r6",        0, 8'h5E, 1, 0, 0,   0, 0, 0, 9'h140);
        add("ina_r0",        0, 8'hF0, 1, 0, 0,   0, 0, 0, 9'h141);
        add("sta_r2_stall",  0, 8'h62, 1, 0, 0,   1, 1, 0, 9'h041);
        add("dec_drain_a",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h001);
        add("dec_drain_b",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);
        add("inc_r1_s",      0, 8'h41, 1, 0, 0,   0, 0, 0, 9'h002);
        add("set_idle_a",    0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("set_idle_b",    0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("mvi_r1_overlap",0, 8'h59, 1, 0, 0,   0, 0, 0, 9'h002);
        add("ovl_drain_a",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("ovl_drain_b",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h002);
        add("ovl_drain_c",   0, 8'h00, 0, 0, 0,   0, 0, 0, 9'h000);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the middle of a flush window returns straight to RUN.
        apply(mk("lpc_pre_rst",   0, 8'h00, 0, 1, 0,  1, 0, 1, 9'h000));
        apply(mk("rst_in_flush",  1, 8'h41, 1, 0, 0,  0, 0, 0, 9'h000));
        apply(mk("run_after_rst", 0, 8'h41, 1, 0, 0,  0, 0, 0, 9'h002));

        // Reset in the middle of a stall clears the scoreboard.
        apply(mk("stall_pre_rst", 0, 8'h21, 1, 0, 0,  1, 1, 0, 9'h002));
        apply(mk("rst_in_stall",  1, 8'h21, 1, 0, 0,  0, 0, 0, 9'h000));
        apply(mk("issue_after_rst",0, 8'h21, 1, 0, 0, 0, 0, 0, 9'h002));

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d queued expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
